vga_text_scheduler: RTL and testbench



---
 rtl/vga_text_scheduler_pkg.sv | 42 ++++
 rtl/vga_text_scheduler_if.sv | 39 +++
 rtl/vga_text_scheduler_timing.sv | 76 +++++++
 rtl/vga_text_scheduler.sv | 116 +++++++++++
 tb/tb_vga_text_scheduler.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_text_scheduler_pkg.sv
// Shared timing constants, cell geometry and stage-2 sideband type for the VGA text scheduler.
// Optional blinking cursor is enabled with `define VGA_TEXT_CURSOR_EN.
package vga_text_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int unsigned HS_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int unsigned HS_END   = HS_START + DEF_H_SYNC - 1;
   localparam int unsigned VS_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int unsigned VS_END   = VS_START + DEF_V_SYNC - 1;

   localparam int unsigned CELL_W = 8;
   localparam int unsigned CELL_H = 16;
   localparam int unsigned CNT_W  = 10;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       blank;
      logic [2:0] columna;
      logic [3:0] fila;
   } sideband_t;

   localparam sideband_t SIDEBAND_RST = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1,
                                          columna: 3'd0, fila: 4'd0};

   function automatic logic in_window(cnt_t x, cnt_t lo, cnt_t hi);
      return (x >= lo) && (x <= hi);
   endfunction

endpackage

// File: rtl/vga_text_scheduler_if.sv
// Memory-fetch and pixel-stage bundle of the VGA text scheduler.
// Cursor position inputs exist only with `define VGA_TEXT_CURSOR_EN.
interface vga_text_scheduler_if #(
   parameter int unsigned TADDR_W = 12
);
   logic [TADDR_W-1:0] text_addr;
   logic [7:0]         text_data;
   logic [11:0]        font_addr;
   logic [7:0]         font_data;
   logic [7:0]         caracter_fila;
   logic [2:0]         columna;
   logic [3:0]         fila;
   logic               hsync;
   logic               vsync;
   logic               VGA_blank;
   logic               frame_start;
`ifdef VGA_TEXT_CURSOR_EN
   logic [6:0]         cursor_col;
   logic [4:0]         cursor_row;
`endif

   modport master (
      output text_addr, font_addr, caracter_fila, columna, fila,
      output hsync, vsync, VGA_blank, frame_start,
`ifdef VGA_TEXT_CURSOR_EN
      input  cursor_col, cursor_row,
`endif
      input  text_data, font_data
   );

   modport slave (
      input  text_addr, font_addr, caracter_fila, columna, fila,
      input  hsync, vsync, VGA_blank, frame_start,
`ifdef VGA_TEXT_CURSOR_EN
      output cursor_col, cursor_row,
`endif
      output text_data, font_data
   );
endinterface

// File: rtl/vga_text_scheduler_timing.sv
// Stage-0 raster timing: h/v counters, raw sync/blank and the frame_start pulse.
// Counters hold at 0 for one cycle after reset so h=0,v=0 is the first cycle with rst low.
module vga_timing_gen
   import vga_text_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic clk,
   input  logic rst,
   output cnt_t h_cnt_o,
   output cnt_t v_cnt_o,
   output logic h_wrap_o,
   output logic v_wrap_o,
   output logic live_o,
   output logic hsync0_o,
   output logic vsync0_o,
   output logic blank0_o,
   output logic frame_start_o
);
   localparam cnt_t H_LAST = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t V_LAST = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
   localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
   localparam cnt_t HS_LO  = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t HS_HI  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam cnt_t VS_LO  = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t VS_HI  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   cnt_t h_q, h_d, v_q, v_d;
   logic run_q, fs_q, fs_d;

   assign h_wrap_o = run_q && (h_q == H_LAST);
   assign v_wrap_o = h_wrap_o && (v_q == V_LAST);

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (h_wrap_o) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
      end else if (run_q) begin
         h_d = h_q + cnt_t'(1);
      end
      fs_d = (h_d == '0) && (v_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q   <= '0;
         v_q   <= '0;
         run_q <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         run_q <= 1'b1;
         fs_q  <= fs_d;
      end
   end

   assign h_cnt_o       = h_q;
   assign v_cnt_o       = v_q;
   assign live_o        = run_q;
   assign frame_start_o = fs_q;
   assign blank0_o      = (h_q >= H_ACT) || (v_q >= V_ACT);
   assign hsync0_o      = !in_window(h_q, HS_LO, HS_HI);
   assign vsync0_o      = !in_window(v_q, VS_LO, VS_HI);

endmodule

// File: rtl/vga_text_scheduler.sv
// VGA text-mode fetch sequencer: text RAM then font ROM fetch per cell, sideband aligned 2 cycles.
// Optional blinking cursor block (bottom two glyph lines) with `define VGA_TEXT_CURSOR_EN.
module vga_text_scheduler
   import vga_text_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned COLS     = 80,
   parameter int unsigned ROWS     = 30,
   parameter int unsigned TADDR_W  = 12
) (
   input logic                 clk,
   input logic                 rst,
   vga_text_scheduler_if.master bus
);
   localparam cnt_t ROW_END = cnt_t'(ROWS * CELL_H);

   cnt_t      h_cnt, v_cnt;
   logic      h_wrap, v_wrap, live, hsync0, vsync0, blank0;
   sideband_t sb0, sb1_q, sb2_q;
   logic      live1_q, live2_q;
   logic [TADDR_W-1:0] row_base_q, row_base_d;
   logic [7:0] glyph;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(clk), .rst(rst),
      .h_cnt_o(h_cnt), .v_cnt_o(v_cnt),
      .h_wrap_o(h_wrap), .v_wrap_o(v_wrap), .live_o(live),
      .hsync0_o(hsync0), .vsync0_o(vsync0), .blank0_o(blank0),
      .frame_start_o(bus.frame_start)
   );

   // Row base advances by COLS after the last line of each character row.
   always_comb begin
      row_base_d = row_base_q;
      if (v_wrap) begin
         row_base_d = '0;
      end else if (h_wrap && (v_cnt[3:0] == 4'hF) && (v_cnt < ROW_END)) begin
         row_base_d = row_base_q + TADDR_W'(COLS);
      end
   end

   assign bus.text_addr = blank0 ? '0 : row_base_q + TADDR_W'(h_cnt[CNT_W-1:3]);

   assign sb0 = '{hsync: hsync0, vsync: vsync0, blank: blank0,
                  columna: h_cnt[2:0], fila: v_cnt[3:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         row_base_q <= '0;
         sb1_q      <= SIDEBAND_RST;
         sb2_q      <= SIDEBAND_RST;
         live1_q    <= 1'b0;
         live2_q    <= 1'b0;
      end else begin
         row_base_q <= row_base_d;
         sb1_q      <= live ? sb0 : SIDEBAND_RST;
         sb2_q      <= sb1_q;
         live1_q    <= live;
         live2_q    <= live1_q;
      end
   end

   assign bus.font_addr = live1_q ? {sb1_q.fila, bus.text_data} : '0;

`ifdef VGA_TEXT_CURSOR_EN
   logic [6:0] col1_q, col2_q;
   logic [4:0] row1_q, row2_q;
   logic [5:0] frame_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         col1_q  <= '0;
         col2_q  <= '0;
         row1_q  <= '0;
         row2_q  <= '0;
         frame_q <= '0;
      end else begin
         col1_q  <= h_cnt[CNT_W-1:3];
         col2_q  <= col1_q;
         row1_q  <= v_cnt[8:4];
         row2_q  <= row1_q;
         frame_q <= v_wrap ? frame_q + 6'd1 : frame_q;
      end
   end
`endif

   // The ROM word arrives in the stage-2 cycle itself, so the glyph is muxed, not re-registered;
   // live2_q masks it to 0 until the pipeline has refilled after reset.
   always_comb begin
      glyph = live2_q ? bus.font_data : '0;
`ifdef VGA_TEXT_CURSOR_EN
      if (live2_q && frame_q[5] && (col2_q == bus.cursor_col) &&
          (row2_q == bus.cursor_row) && (sb2_q.fila >= 4'd14)) begin
         glyph = 8'hFF;
      end
`endif
   end

   assign bus.caracter_fila = glyph;
   assign bus.columna       = sb2_q.columna;
   assign bus.fila          = sb2_q.fila;
   assign bus.hsync         = sb2_q.hsync;
   assign bus.vsync         = sb2_q.vsync;
   assign bus.VGA_blank     = sb2_q.blank;

endmodule

// File: tb/tb_vga_text_scheduler.sv
// Self-checking bench for vga_text_scheduler on a reduced raster, randomized memories and resets.
module tb_vga_text_scheduler;

   localparam int HA = 64, HFP = 8, HSW = 16, HBP = 8;
   localparam int VA = 64, VFP = 3, VSW = 2, VBP = 4;
   localparam int NCOL = 8, NROW = 4;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_text_scheduler_if #(.TADDR_W(12)) bus ();

   vga_text_scheduler #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .COLS(NCOL), .ROWS(NROW), .TADDR_W(12)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [7:0] ram [0:4095];
   logic [7:0] rom [0:4095];

   always @(posedge clk) begin
      bus.text_data <= ram[bus.text_addr];
      bus.font_data <= rom[bus.font_addr];
   end

   // p: pixel index since the last reset (h=0,v=0 at p=0); -1 on cycles following a reset edge.
   int p = -1;
   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   logic hs_prev = 1'b1, vs_prev = 1'b1;
   int hs_fall = -1, vs_fall = -1, fs_last = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (p=%0d)", tag, obs, exp, p);
      end
   endtask

   function automatic int hh(input int i);
      return i % HT;
   endfunction

   function automatic int vv(input int i);
      return (i / HT) % VT;
   endfunction

   function automatic bit is_blank(input int i);
      return (hh(i) >= HA) || (vv(i) >= VA);
   endfunction

   function automatic int exp_taddr(input int i);
      if (is_blank(i)) return 0;
      return (vv(i) / 16) * NCOL + hh(i) / 8;
   endfunction

   function automatic int exp_faddr(input int i);
      return ((vv(i) % 16) * 256) + int'(ram[exp_taddr(i)]);
   endfunction

   function automatic int exp_glyph(input int q, input int now);
      int g;
      g = int'(rom[exp_faddr(q)]);
`ifdef VGA_TEXT_CURSOR_EN
      if ((((now / FRAME) >> 5) & 1) == 1 && (hh(q) / 8) == int'(bus.cursor_col) &&
          (vv(q) / 16) == int'(bus.cursor_row) && (vv(q) % 16) >= 14)
         g = 8'hFF;
`else
      if (now < 0) g = 0;
`endif
      return g;
   endfunction

   task automatic check_stage2_reset();
      chk("cf_rst", bus.caracter_fila, 0);
      chk("columna_rst", bus.columna, 0);
      chk("fila_rst", bus.fila, 0);
      chk("hsync_rst", bus.hsync, 1);
      chk("vsync_rst", bus.vsync, 1);
      chk("blank_rst", bus.VGA_blank, 1);
   endtask

   task automatic check_cycle();
      int q;
      if (p < 0) begin
         chk("rst_text_addr", bus.text_addr, 0);
         chk("rst_font_addr", bus.font_addr, 0);
         chk("rst_frame_start", bus.frame_start, 0);
         check_stage2_reset();
         hs_prev = 1'b1; vs_prev = 1'b1;
         hs_fall = -1; vs_fall = -1; fs_last = -1;
         return;
      end
      chk("text_addr", bus.text_addr, exp_taddr(p));
      chk("frame_start", bus.frame_start, (hh(p) == 0 && vv(p) == 0));
      chk("font_addr", bus.font_addr, (p >= 1) ? exp_faddr(p - 1) : 0);
      if (hh(p) == 0 && vv(p) == 16) chk("row1_base", bus.text_addr, NCOL);
      if (hh(p) == HA - 1 && vv(p) == VA - 1) chk("last_addr", bus.text_addr, NROW * NCOL - 1);
      if (p < 2) begin
         check_stage2_reset();
      end else begin
         q = p - 2;
         chk("caracter_fila", bus.caracter_fila, exp_glyph(q, p));
         chk("columna", bus.columna, hh(q) % 8);
         chk("fila", bus.fila, vv(q) % 16);
         chk("hsync", bus.hsync, !(hh(q) >= HA + HFP && hh(q) < HA + HFP + HSW));
         chk("vsync", bus.vsync, !(vv(q) >= VA + VFP && vv(q) < VA + VFP + VSW));
         chk("blank", bus.VGA_blank, is_blank(q));
         if (vv(q) == 19 && hh(q) >= 8 && hh(q) < 16) begin
            chk("cell_glyph", bus.caracter_fila, 8'h3C);
            chk("cell_fila", bus.fila, 3);
            chk("cell_col_step", bus.columna, hh(q) - 8);
         end
         if (hh(q) == HA && vv(q) < VA) begin
            chk("blank_rise", bus.VGA_blank, 1);
            chk("col_wrap", bus.columna, 0);
         end
      end
      if (hs_prev && !bus.hsync) begin
         if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, HT);
         hs_fall = cyc;
      end
      if (!hs_prev && bus.hsync && hs_fall >= 0) chk("hs_width", cyc - hs_fall, HSW);
      hs_prev = bus.hsync;
      if (vs_prev && !bus.vsync) begin
         if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, FRAME);
         vs_fall = cyc;
      end
      if (!vs_prev && bus.vsync && vs_fall >= 0) chk("vs_width", cyc - vs_fall, VSW * HT);
      vs_prev = bus.vsync;
      if (bus.frame_start) begin
         if (fs_last >= 0) chk("fs_period", cyc - fs_last, FRAME);
         fs_last = cyc;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) p = -1;
      else     p = p + 1;
      cyc++;
      @(negedge clk);
      check_cycle();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 4096; i++) begin
         ram[i] = 8'($urandom);
         rom[i] = 8'($urandom);
      end
      ram[NCOL + 1]       = 8'h41;
      rom[{4'd3, 8'h41}] = 8'h3C;
`ifdef VGA_TEXT_CURSOR_EN
      bus.cursor_col = 7'($urandom_range(0, NCOL - 1));
      bus.cursor_row = 5'($urandom_range(0, NROW - 1));
`endif
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      run(2 * FRAME + 500);

      guard = 0;
      while (!(p >= 0 && vv(p) == 20 && hh(p) == 30) && guard < 2 * FRAME) begin
         step();
         guard++;
      end
      if (guard >= 2 * FRAME) chk("reach_midframe", 0, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("restart_fs", bus.frame_start, 1);
      run(FRAME / 2);

      for (int k = 0; k < 3; k++) begin
         run($urandom_range(50, FRAME / 2));
         rst = 1'b1;
         run($urandom_range(1, 3));
         rst = 1'b0;
      end
      run(3 * HT);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
